multicycle_controller: RTL and testbench

//  Multi-cycle sequencer for the LEGv8 core: fetch, decode, execute, memory, writeback.

---
 rtl/multicycle_controller_pkg.sv | 42 ++++
 rtl/multicycle_controller_classifier.sv | 39 +++
 rtl/multicycle_controller.sv | 164 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle sequencer.
package multicycle_controller_pkg;

   localparam int INSTR_LEN = 32;

   typedef enum logic [2:0] {
      CTL_IDLE   = 3'd0,
      CTL_FETCH  = 3'd1,
      CTL_DECODE = 3'd2,
      CTL_EXEC   = 3'd3,
      CTL_MEM    = 3'd4,
      CTL_WB     = 3'd5,
      CTL_FAULT  = 3'd6
   } ctl_state_t;

   typedef enum logic [3:0] {
      CLS_ILLEGAL = 4'd0,
      CLS_ALU_R   = 4'd1,
      CLS_ALU_I   = 4'd2,
      CLS_SHIFT   = 4'd3,
      CLS_LOAD    = 4'd4,
      CLS_STORE   = 4'd5,
      CLS_CBRANCH = 4'd6,
      CLS_UBRANCH = 4'd7,
      CLS_LINK    = 4'd8,
      CLS_MOV     = 4'd9
   } cls_t;

   localparam logic [1:0] RF_WSEL_ALU  = 2'd0;
   localparam logic [1:0] RF_WSEL_MEM  = 2'd1;
   localparam logic [1:0] RF_WSEL_LINK = 2'd2;

   // CBZ/CBNZ test the ALU zero flag; every other conditional branch is B.cond.
   function automatic logic cbranch_taken(input logic [10:0] op,
                                          input logic       alu_zero,
                                          input logic       cond_taken);
      if (op[10:3] == 8'b10110100) return alu_zero;
      if (op[10:3] == 8'b10110101) return !alu_zero;
      return cond_taken;
   endfunction

endpackage

// File: rtl/multicycle_controller_classifier.sv
// Opcode classifier: groups instr[31:21] the same way the sign extender
// groups immediate formats.
module multicycle_controller_classifier
   import multicycle_controller_pkg::*;
(
   input  logic [10:0] opcode,
   output cls_t        cls
);

   // Pattern match the 11-bit opcode field into an instruction class.
   always_comb begin
      cls = CLS_ILLEGAL;
      casez (opcode)
         // ADD, SUB, AND, ORR, EOR, ADDS, SUBS, ANDS
         11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
         11'b11001010000, 11'b10101011000, 11'b11101011000, 11'b11101010000:
            cls = CLS_ALU_R;
         // ADDI, SUBI, ANDI, ORRI, ADDIS, SUBIS, EORI, ANDIS
         11'b1001000100?, 11'b1101000100?, 11'b1001001000?, 11'b1011001000?,
         11'b1011000100?, 11'b1111000100?, 11'b1101001000?, 11'b1111001000?:
            cls = CLS_ALU_I;
         // LSR, LSL
         11'b11010011010, 11'b11010011011:
            cls = CLS_SHIFT;
         11'b11111000010: cls = CLS_LOAD;
         11'b11111000000: cls = CLS_STORE;
         // CBZ, CBNZ, B.cond
         11'b10110100???, 11'b10110101???, 11'b01010100???:
            cls = CLS_CBRANCH;
         11'b000101?????: cls = CLS_UBRANCH;
         11'b100101?????: cls = CLS_LINK;
         // MOVZ, MOVK
         11'b110100101??, 11'b111100101??:
            cls = CLS_MOV;
         default: cls = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the LEGv8 core: state register, instruction
// register, memory-handshake timeout and Moore control decode.
//
//  state      | meaning
//  -----------+-----------------------------------------------------
//  CTL_IDLE   | parked, waits for run
//  CTL_FETCH  | imem_req held until imem_ready or timeout
//  CTL_DECODE | one cycle, classify the latched instruction
//  CTL_EXEC   | ALU operand select; branches update PC and retire
//  CTL_MEM    | dmem_req held until dmem_ready or timeout; STUR retires
//  CTL_WB     | register write, PC+4, retire
//  CTL_FAULT  | sticky fault, everything quiet until reset
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 run,
   output logic                 imem_req,
   input  logic                 imem_ready,
   input  logic [INSTR_LEN-1:0] imem_rdata,
   output logic [INSTR_LEN-1:0] instr,
   output logic                 dmem_req,
   output logic                 dmem_we,
   input  logic                 dmem_ready,
   input  logic                 alu_zero,
   input  logic                 cond_taken,
   output logic                 alu_src_imm,
   output logic                 pc_we,
   output logic                 pc_src,
   output logic                 rf_we,
   output logic [1:0]           rf_wsel,
   output logic                 retired,
   output logic                 fault
);

   localparam int              CW       = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0]   TMO_LAST = CW'(MEM_TIMEOUT - 1);
   localparam logic [CW-1:0]   TMO_MAX  = CW'(MEM_TIMEOUT);

   ctl_state_t    state, state_nx, boundary;
   cls_t          cls;
   logic [CW-1:0] tmo_cnt;
   logic          tmo_hit;
   logic          branch_taken;

   multicycle_controller_classifier u_classifier (
      .opcode (instr[31:21]),
      .cls    (cls)
   );

   // The last waiting cycle of a handshake; a ready in that cycle still wins.
   assign tmo_hit      = (tmo_cnt >= TMO_LAST);
   assign branch_taken = cbranch_taken(instr[31:21], alu_zero, cond_taken);
   assign boundary     = run ? CTL_FETCH : CTL_IDLE;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= CTL_IDLE;
      else          state <= state_nx;
   end

   // Instruction register, loaded on the fetch handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          instr <= '0;
      else if (state == CTL_FETCH && imem_ready) instr <= imem_rdata;
   end

   // Handshake wait counter: cleared on every state change, so STUR->FETCH restarts it too.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         tmo_cnt <= '0;
      else if (state_nx != state)
         tmo_cnt <= '0;
      else if ((state == CTL_FETCH || state == CTL_MEM) && tmo_cnt != TMO_MAX)
         tmo_cnt <= tmo_cnt + 1'b1;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         CTL_IDLE:   if (run) state_nx = CTL_FETCH;
         CTL_FETCH: begin
            if (imem_ready)   state_nx = CTL_DECODE;
            else if (tmo_hit) state_nx = CTL_FAULT;
         end
         CTL_DECODE: state_nx = (cls == CLS_ILLEGAL) ? CTL_FAULT : CTL_EXEC;
         CTL_EXEC: begin
            case (cls)
               CLS_CBRANCH, CLS_UBRANCH, CLS_LINK: state_nx = boundary;
               CLS_LOAD, CLS_STORE:                state_nx = CTL_MEM;
               default:                            state_nx = CTL_WB;
            endcase
         end
         CTL_MEM: begin
            if (dmem_ready)   state_nx = (cls == CLS_STORE) ? boundary : CTL_WB;
            else if (tmo_hit) state_nx = CTL_FAULT;
         end
         CTL_WB:    state_nx = boundary;
         CTL_FAULT: state_nx = CTL_FAULT;
         default:   state_nx = CTL_IDLE;
      endcase
   end

   // Control strobes decoded from state and instruction class.
   always_comb begin
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      alu_src_imm = 1'b0;
      pc_we       = 1'b0;
      pc_src      = 1'b0;
      rf_we       = 1'b0;
      rf_wsel     = RF_WSEL_ALU;
      retired     = 1'b0;
      fault       = 1'b0;
      case (state)
         CTL_FETCH: imem_req = 1'b1;
         CTL_EXEC: begin
            alu_src_imm = cls inside {CLS_ALU_I, CLS_SHIFT, CLS_LOAD, CLS_STORE};
            case (cls)
               CLS_UBRANCH: begin
                  pc_we   = 1'b1;
                  pc_src  = 1'b1;
                  retired = 1'b1;
               end
               CLS_LINK: begin
                  pc_we   = 1'b1;
                  pc_src  = 1'b1;
                  rf_we   = 1'b1;
                  rf_wsel = RF_WSEL_LINK;
                  retired = 1'b1;
               end
               CLS_CBRANCH: begin
                  pc_we   = 1'b1;
                  pc_src  = branch_taken;
                  retired = 1'b1;
               end
               default: ;
            endcase
         end
         CTL_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (cls == CLS_STORE);
            if (cls == CLS_STORE && dmem_ready) begin
               pc_we   = 1'b1;
               retired = 1'b1;
            end
         end
         CTL_WB: begin
            rf_we   = 1'b1;
            rf_wsel = (cls == CLS_LOAD) ? RF_WSEL_MEM : RF_WSEL_ALU;
            pc_we   = 1'b1;
            retired = 1'b1;
         end
         CTL_FAULT: fault = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected traces built from
// the instruction-level rules (phases, latencies, handshakes).
module tb_multicycle_controller;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        run = 1'b0;
   logic        imem_req;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instr;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ready = 1'b0;
   logic        alu_zero = 1'b0;
   logic        cond_taken = 1'b0;
   logic        alu_src_imm;
   logic        pc_we;
   logic        pc_src;
   logic        rf_we;
   logic [1:0]  rf_wsel;
   logic        retired;
   logic        fault;

   int checks = 0;
   int errors = 0;

   multicycle_controller #(.MEM_TIMEOUT(TMO)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .run         (run),
      .imem_req    (imem_req),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_ready  (dmem_ready),
      .alu_zero    (alu_zero),
      .cond_taken  (cond_taken),
      .alu_src_imm (alu_src_imm),
      .pc_we       (pc_we),
      .pc_src      (pc_src),
      .rf_we       (rf_we),
      .rf_wsel     (rf_wsel),
      .retired     (retired),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   typedef enum int {
      K_ALU_R, K_ALU_I, K_SHIFT, K_LOAD, K_STORE, K_CBZ, K_CBNZ,
      K_BCOND, K_B, K_BL, K_MOV, K_ILL
   } kind_t;

   localparam logic [2:0] PH_IDLE = 3'd0, PH_FWAIT = 3'd1, PH_FETCH = 3'd2,
                          PH_DEC = 3'd3, PH_EXEC = 3'd4, PH_MWAIT = 3'd5,
                          PH_MEM = 3'd6, PH_WB = 3'd7;
   localparam logic [2:0] PH_FAULT = PH_IDLE; // fault cycles are identified by exp[0]

   typedef struct packed {
      logic        ir;
      logic        dr;
      logic        rn;
      logic [10:0] exp;
      logic [2:0]  ph;
   } cyc_t;

   function automatic string phname(input logic [2:0] p, input logic flt);
      if (flt) return "fault";
      case (p)
         PH_IDLE:  return "idle";
         PH_FWAIT: return "fetch_wait";
         PH_FETCH: return "fetch";
         PH_DEC:   return "decode";
         PH_EXEC:  return "exec";
         PH_MWAIT: return "mem_wait";
         PH_MEM:   return "mem";
         default:  return "wb";
      endcase
   endfunction

   // {imem_req, dmem_req, dmem_we, alu_src_imm, pc_we, pc_src, rf_we, rf_wsel, retired, fault}
   function automatic logic [10:0] outs();
      return {imem_req, dmem_req, dmem_we, alu_src_imm, pc_we, pc_src, rf_we,
              rf_wsel, retired, fault};
   endfunction

   function automatic logic [10:0] ev(input bit ireq, input bit dreq, input bit we,
                                      input bit imm, input bit pcwe, input bit pcsrc,
                                      input bit rfwe, input logic [1:0] wsel,
                                      input bit ret, input bit flt);
      return {ireq, dreq, we, imm, pcwe, pcsrc, rfwe, wsel, ret, flt};
   endfunction

   function automatic logic [31:0] make_instr(input kind_t k);
      logic [10:0] op;
      int s;
      s  = $urandom_range(0, 7);
      op = 11'h000;
      case (k)
         K_ALU_R: case (s)
            0: op = 11'h458; 1: op = 11'h658; 2: op = 11'h450; 3: op = 11'h550;
            4: op = 11'h650; 5: op = 11'h558; 6: op = 11'h758; default: op = 11'h750;
         endcase
         K_ALU_I: begin
            case (s)
               0: op = 11'h488; 1: op = 11'h688; 2: op = 11'h490; 3: op = 11'h590;
               4: op = 11'h588; 5: op = 11'h788; 6: op = 11'h690; default: op = 11'h790;
            endcase
            op[0] = 1'($urandom_range(0, 1));
         end
         K_SHIFT: op = (s < 4) ? 11'h69A : 11'h69B;
         K_LOAD:  op = 11'h7C2;
         K_STORE: op = 11'h7C0;
         K_CBZ:   op = 11'h5A0 + 11'(s);
         K_CBNZ:  op = 11'h5A8 + 11'(s);
         K_BCOND: op = 11'h2A0 + 11'(s);
         K_B:     op = 11'h0A0 + 11'($urandom_range(0, 31));
         K_BL:    op = 11'h4A0 + 11'($urandom_range(0, 31));
         K_MOV:   op = ((s < 4) ? 11'h694 : 11'h794) + 11'($urandom_range(0, 3));
         default: op = (s < 4) ? 11'h000 : 11'h7FF;
      endcase
      return {op, 21'($urandom)};
   endfunction

   task automatic do_reset();
      reset_n    = 1'b0;
      run        = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   // Runs one instruction from IDLE (or from FETCH entry when in_fetch=1).
   // fop >= 0 forces the opcode field. Waits >= TMO model a timeout.
   task automatic run_instr(input string name, input kind_t k, input int fop,
                            input int iwait, input int dwait, input bit az,
                            input bit ct, input bit in_fetch, input bit run_after);
      cyc_t        q[$];
      logic [31:0] iw;
      bit          is_br, is_mem, taken, dead, imm;
      int          start, ret_idx, exp_lat, obs_lat;
      iw = make_instr(k);
      if (fop >= 0) iw[31:21] = 11'(fop);
      alu_zero   = az;
      cond_taken = ct;
      is_br  = k inside {K_CBZ, K_CBNZ, K_BCOND, K_B, K_BL};
      is_mem = k inside {K_LOAD, K_STORE};
      imm    = k inside {K_ALU_I, K_SHIFT, K_LOAD, K_STORE};
      taken  = (k == K_B || k == K_BL) ? 1'b1 : (k == K_CBZ) ? az : (k == K_CBNZ) ? !az : ct;
      dead   = 1'b0;

      if (!in_fetch)
         q.push_back('{ir: 1'($urandom_range(0, 1)), dr: 1'($urandom_range(0, 1)),
                       rn: 1'b1, exp: 11'd0, ph: PH_IDLE});
      for (int i = 0; i < iwait && i < TMO; i++)
         q.push_back('{ir: 1'b0, dr: 1'b0, rn: 1'b1,
                       exp: ev(1,0,0,0,0,0,0,2'd0,0,0), ph: PH_FWAIT});
      if (iwait >= TMO) dead = 1'b1;
      else begin
         q.push_back('{ir: 1'b1, dr: 1'b0, rn: 1'b1,
                       exp: ev(1,0,0,0,0,0,0,2'd0,0,0), ph: PH_FETCH});
         q.push_back('{ir: 1'b0, dr: 1'b0, rn: 1'b1, exp: 11'd0, ph: PH_DEC});
         if (k == K_ILL) dead = 1'b1;
      end
      if (!dead) begin
         if (is_br)
            q.push_back('{ir: 1'b0, dr: 1'b0, rn: run_after, ph: PH_EXEC,
                          exp: ev(0,0,0,0,1,taken,k == K_BL,(k == K_BL) ? 2'd2 : 2'd0,1,0)});
         else
            q.push_back('{ir: 1'b0, dr: 1'b0, rn: run_after, ph: PH_EXEC,
                          exp: ev(0,0,0,imm,0,0,0,2'd0,0,0)});
         if (is_mem) begin
            for (int i = 0; i < dwait && i < TMO; i++)
               q.push_back('{ir: 1'b0, dr: 1'b0, rn: run_after, ph: PH_MWAIT,
                             exp: ev(0,1,k == K_STORE,0,0,0,0,2'd0,0,0)});
            if (dwait >= TMO) dead = 1'b1;
            else if (k == K_STORE)
               q.push_back('{ir: 1'b0, dr: 1'b1, rn: run_after, ph: PH_MEM,
                             exp: ev(0,1,1,0,1,0,0,2'd0,1,0)});
            else
               q.push_back('{ir: 1'b0, dr: 1'b1, rn: run_after, ph: PH_MEM,
                             exp: ev(0,1,0,0,0,0,0,2'd0,0,0)});
         end
         if (!dead && !is_br && k != K_STORE)
            q.push_back('{ir: 1'b0, dr: 1'b0, rn: run_after, ph: PH_WB,
                          exp: ev(0,0,0,0,1,0,1,(k == K_LOAD) ? 2'd1 : 2'd0,1,0)});
      end
      if (dead)
         for (int i = 0; i < 4; i++)
            q.push_back('{ir: 1'($urandom_range(0, 1)), dr: 1'($urandom_range(0, 1)),
                          rn: 1'($urandom_range(0, 1)), ph: PH_FAULT,
                          exp: ev(0,0,0,0,0,0,0,2'd0,0,1)});

      ret_idx = -1;
      foreach (q[i]) begin
         run        = q[i].rn;
         imem_ready = q[i].ir;
         imem_rdata = q[i].ir ? iw : $urandom;
         dmem_ready = q[i].dr;
         @(negedge clk);
         checks++;
         if (outs() !== q[i].exp) begin
            errors++;
            $display("FAIL %s %s cycle %0d: outputs got %b expected %b",
                     name, phname(q[i].ph, q[i].exp[0]), i, outs(), q[i].exp);
         end
         if (q[i].ph == PH_DEC && !q[i].exp[0]) begin
            checks++;
            if (instr !== iw) begin
               errors++;
               $display("FAIL %s instr: got %h expected %h", name, instr, iw);
            end
         end
         if (retired === 1'b1 && ret_idx < 0) ret_idx = i;
         @(posedge clk);
         #1;
      end

      if (!dead) begin
         start   = in_fetch ? 0 : 1;
         exp_lat = (is_br ? 3 : (k == K_STORE) ? 4 : (k == K_LOAD) ? 5 : 4)
                   + iwait + (is_mem ? dwait : 0);
         obs_lat = (ret_idx < 0) ? -1 : ret_idx - start + 1;
         checks++;
         if (obs_lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, obs_lat, exp_lat);
         end
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (outs() !== 11'd0) begin
         errors++;
         $display("FAIL reset outputs: got %b expected %b", outs(), 11'd0);
      end
      checks++;
      if (instr !== 32'd0) begin
         errors++;
         $display("FAIL reset instr: got %h expected %h", instr, 32'd0);
      end
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_directed();
      run_instr("addi",        K_ALU_I, 'h488, 0, 0, 0, 0, 0, 0);
      run_instr("ldur_wait3",  K_LOAD,  'h7C2, 0, 3, 0, 0, 0, 0);
      run_instr("cbz_taken",   K_CBZ,   'h5A0, 0, 0, 1, 0, 0, 0);
      run_instr("cbz_nottaken",K_CBZ,   'h5A0, 0, 0, 0, 0, 0, 0);
      run_instr("cbnz_taken",  K_CBNZ,  -1,    0, 0, 0, 0, 0, 0);
      run_instr("bcond_taken", K_BCOND, -1,    0, 0, 1, 1, 0, 0);
      run_instr("bcond_not",   K_BCOND, -1,    0, 0, 0, 0, 0, 0);
      run_instr("bl",          K_BL,    'h4A0, 0, 0, 0, 0, 0, 1);
      run_instr("after_bl",    K_ALU_R, -1,    0, 0, 0, 0, 1, 0);
      run_instr("stur_limit",  K_STORE, -1, TMO-1, TMO-1, 0, 0, 0, 0);
      run_instr("mov",         K_MOV,   -1,    1, 0, 0, 0, 0, 0);
      run_instr("lsl",         K_SHIFT, -1,    0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      run_instr("b2b_stur", K_STORE, -1, 0, 0, 0, 0, 0, 1);
      run_instr("b2b_b",    K_B,     -1, 0, 0, 0, 0, 1, 1);
      run_instr("b2b_ldur", K_LOAD,  -1, 2, 1, 0, 0, 1, 1);
      run_instr("b2b_add",  K_ALU_R, -1, 0, 0, 0, 0, 1, 0);
   endtask

   task automatic test_random();
      bit nf, ra;
      int iw_, dw_;
      nf = 1'b0;
      for (int i = 0; i < 40; i++) begin
         ra  = (i == 39) ? 1'b0 : 1'($urandom_range(0, 1));
         iw_ = ($urandom_range(0, 7) == 0) ? TMO - 1 : int'($urandom_range(0, 3));
         dw_ = ($urandom_range(0, 7) == 0) ? TMO - 1 : int'($urandom_range(0, 3));
         run_instr("random", kind_t'($urandom_range(0, 10)), -1, iw_, dw_,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nf, ra);
         nf = ra;
      end
   endtask

   task automatic test_faults();
      run_instr("illegal",       K_ILL,   'h000, 0, 0, 0, 0, 0, 0);
      do_reset();
      run_instr("fetch_timeout", K_ALU_R, -1, TMO, 0, 0, 0, 0, 0);
      do_reset();
      run_instr("mem_timeout",   K_STORE, -1, 0, TMO, 0, 0, 0, 0);
      do_reset();
      run_instr("after_fault",   K_ALU_I, -1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mid_mem();
      logic [31:0] iw;
      iw = make_instr(K_LOAD);
      run = 1'b1;
      @(posedge clk); #1;
      imem_ready = 1'b1;
      imem_rdata = iw;
      @(posedge clk); #1;
      imem_ready = 1'b0;
      run        = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b1) begin
         errors++;
         $display("FAIL mid_mem dmem_req: got %b expected 1", dmem_req);
      end
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (outs() !== 11'd0) begin
         errors++;
         $display("FAIL async_reset outputs: got %b expected %b", outs(), 11'd0);
      end
      checks++;
      if (instr !== 32'd0) begin
         errors++;
         $display("FAIL async_reset instr: got %h expected %h", instr, 32'd0);
      end
      @(posedge clk);
      #1 reset_n = 1'b1;
      run_instr("after_reset", K_LOAD, -1, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_faults();
      test_reset_mid_mem();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
